// File: rtl/unidad_fetch_if.sv
// unidad_fetch_if: bundles the instruction-memory handshake and the
// fetch-to-decode signals of the fetch stage. The fetch unit is the master,
// and the memory/pipeline environment is the slave.
interface unidad_fetch_if;

    // Instruction memory read channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Pipeline control coming back from decode/execute
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;

    // Output slot towards decode/execute and the extension unit
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus8;
    logic [23:0] imm24;
    logic [1:0]  ext_imm;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  stall,
        input  branch_taken,
        input  branch_target,
        output instr_valid,
        output instr,
        output pc_out,
        output pc_plus8,
        output imm24,
        output ext_imm
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output stall,
        output branch_taken,
        output branch_target,
        input  instr_valid,
        input  instr,
        input  pc_out,
        input  pc_plus8,
        input  imm24,
        input  ext_imm
    );

endinterface

// File: rtl/unidad_fetch.sv
// unidad_fetch: instruction fetch stage of the ARM calculator datapath.
// Issues word reads over a req/ack handshake, keeps the fetched word in a
// registered output slot backed by a one-entry skid buffer, and handles
// stalls and branch redirects (including redirects that land while a read
// is still outstanding, which are resolved by discarding the stale data).
module unidad_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    unidad_fetch_if.master bus
);

    // IDLE: one-cycle post-reset state; WAIT: read outstanding at fetchPc;
    // FULL: skid holds a word, no read issued; DISCARD: stale read still
    // outstanding, its data will be thrown away.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        FULL    = 2'b10,
        DISCARD = 2'b11
    } fetchState_t;

    fetchState_t state_q,      state_d;
    logic [31:0] fetchPc_q,    fetchPc_d;
    logic [31:0] staleAddr_q,  staleAddr_d;
    logic [31:0] skidInstr_q,  skidInstr_d;
    logic [31:0] skidPc_q,     skidPc_d;
    logic        instrValid_q, instrValid_d;
    logic [31:0] instr_q,      instr_d;
    logic [31:0] pcOut_q,      pcOut_d;

    logic        slotFree;
    logic [31:0] branchAddr;
    logic [31:0] fetchPcNext;
    logic [1:0]  extSel;

    // The slot can accept a new word when it is empty or being consumed.
    assign slotFree    = !instrValid_q || !bus.stall;
    // Branch targets are always word aligned; the low two bits are dropped.
    assign branchAddr  = bus.branch_target & 32'hFFFF_FFFC;
    assign fetchPcNext = fetchPc_q + 32'd4;

    // Next-state logic: branch redirect first, then the normal fetch flow.
    always_comb begin
        state_d      = state_q;
        fetchPc_d    = fetchPc_q;
        staleAddr_d  = staleAddr_q;
        skidInstr_d  = skidInstr_q;
        skidPc_d     = skidPc_q;
        instrValid_d = instrValid_q;
        instr_d      = instr_q;
        pcOut_d      = pcOut_q;

        if (bus.branch_taken) begin
            instrValid_d = 1'b0;
            skidInstr_d  = 32'd0;
            skidPc_d     = 32'd0;
            fetchPc_d    = branchAddr;
            case (state_q)
                WAIT: begin
                    if (!bus.imem_ack) begin
                        state_d     = DISCARD;
                        staleAddr_d = fetchPc_q;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state_d = WAIT;
                    end
                end
                default: begin
                    state_d = WAIT;
                end
            endcase
        end else begin
            if (slotFree) begin
                instrValid_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        fetchPc_d = fetchPcNext;
                        if (slotFree) begin
                            instrValid_d = 1'b1;
                            instr_d      = bus.imem_rdata;
                            pcOut_d      = fetchPc_q;
                        end else begin
                            skidInstr_d = bus.imem_rdata;
                            skidPc_d    = fetchPc_q;
                            state_d     = FULL;
                        end
                    end
                end
                FULL: begin
                    if (!bus.stall) begin
                        instrValid_d = 1'b1;
                        instr_d      = skidInstr_q;
                        pcOut_d      = skidPc_q;
                        state_d      = WAIT;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state_d = WAIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output-slot registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetchPc_q    <= RESET_PC;
            staleAddr_q  <= RESET_PC;
            skidInstr_q  <= 32'd0;
            skidPc_q     <= 32'd0;
            instrValid_q <= 1'b0;
            instr_q      <= 32'd0;
            pcOut_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            fetchPc_q    <= fetchPc_d;
            staleAddr_q  <= staleAddr_d;
            skidInstr_q  <= skidInstr_d;
            skidPc_q     <= skidPc_d;
            instrValid_q <= instrValid_d;
            instr_q      <= instr_d;
            pcOut_q      <= pcOut_d;
        end
    end

    // Immediate-extension select decoded from the instruction class bits.
    always_comb begin
        extSel = 2'b00;
        case (instr_q[27:26])
            2'b00:   extSel = 2'b00;
            2'b01:   extSel = 2'b10;
            2'b10:   extSel = 2'b01;
            default: extSel = 2'b11;
        endcase
    end

    assign bus.imem_req    = (state_q == WAIT) || (state_q == DISCARD);
    assign bus.imem_addr   = (state_q == DISCARD) ? staleAddr_q : fetchPc_q;
    assign bus.instr_valid = instrValid_q;
    assign bus.instr       = instr_q;
    assign bus.pc_out      = pcOut_q;
    assign bus.pc_plus8    = pcOut_q + 32'd8;
    assign bus.imm24       = instr_q[23:0];
    assign bus.ext_imm     = extSel;

endmodule

// File: doc/unidad_fetch.md
# unidad_fetch

- Instruction fetch stage of the ARM calculator datapath.
- Issues word reads to instruction memory over a req/ack handshake and holds the fetched instruction in a registered output slot with a one-entry skid buffer.
- Drives the immediate field and the immediate-extension select straight into the extension unit (24-bit `dataI`, 2-bit `ExtImm`) and the current PC into the decode/execute stage.
- Handles downstream stalls and branch redirects, including redirects that land while a memory read is still outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: read request; held high until `imem_ack`.
- `imem_addr`  out  32: word address, stable while `imem_req` is high.
- `imem_ack`  in  1: read data valid this cycle. May coincide with the first `imem_req` cycle.
- `imem_rdata`  in  32: instruction word, sampled when `imem_ack` is high.
- `stall`  in  1: downstream cannot take a new instruction; output slot holds.
- `branch_taken`  in  1: redirect request, single-cycle pulse.
- `branch_target`  in  32: redirect address; bits [1:0] are ignored and forced to 0.
- `instr_valid`  out  1: output slot holds a live instruction.
- `instr`  out  32: instruction in the output slot.
- `pc_out`  out  32: address of `instr`.
- `pc_plus8`  out  32: `pc_out + 8` (ARM PC read value), combinational.
- `imm24`  out  24: `instr[23:0]`, feeds the extension unit `dataI`.
- `ext_imm`  out  2: extension select, feeds the extension unit `ExtImm`.

## Operation
- States:
  - IDLE: reset state. Lasts one cycle, then WAIT.
  - WAIT: `imem_req` = 1, `imem_addr` = fpc.
  - FULL: the skid buffer is occupied; `imem_req` = 0.
  - DISCARD: `imem_req` = 1 with the stale address; the returned data will be dropped.
- `imem_req` is a combinational function of state: high in WAIT and DISCARD only.
- Slot free: `!instr_valid || !stall`.
- WAIT, `imem_ack` high, slot free:
  - Load the output slot (`instr` ← rdata, `pc_out` ← fpc, `instr_valid` ← 1).
  - fpc ← fpc + 4; stay in WAIT. Back-to-back requests are allowed.
- WAIT, `imem_ack` high, slot busy: skid ← {rdata, fpc}, fpc ← fpc + 4, go to FULL.
- FULL with `!stall`: output slot ← skid, go to WAIT.
- Output slot with slot free and no new data: `instr_valid` ← 0.
- `branch_taken` has priority over stall, ack and skid:
  - Next cycle: `instr_valid` = 0, skid is emptied, fpc ← target.
  - From WAIT without `imem_ack` the same cycle: go to DISCARD.
  - From WAIT with `imem_ack` the same cycle: drop the data and stay in WAIT.
  - From FULL or IDLE: go to WAIT.
- DISCARD: hold `imem_addr` at the stale address until `imem_ack`, drop that data, then go to WAIT at fpc. A second `branch_taken` while in DISCARD only updates fpc.
- `ext_imm` decode from `instr[27:26]`:
  - 00 → 2'b00 (data-processing, zero-extend)
  - 01 → 2'b10 (load/store 12-bit offset, sign-extend)
  - 10 → 2'b01 (branch 24-bit, sign-extend)
  - 11 → 2'b11 (zero)
- `pc_out + 8` and fpc + 4 wrap modulo 2^32 with no flag.

## Timing
- Reset values (asynchronous, immediate):
  - `imem_req` 0, `imem_addr` `RESET_PC`
  - `instr_valid` 0, `instr` 0, `pc_out` 0, `pc_plus8` 8
  - `imm24` 0, `ext_imm` 2'b00
  - state IDLE, skid empty
- First `imem_req` appears in the second cycle after `rst_n` deasserts.
- Latency: `imem_ack` in cycle N → `instr_valid` / `instr` updated at the edge ending cycle N (visible in N+1).
- `imm24` and `ext_imm` are combinational from `instr`.
- With a zero-wait memory (ack in the same cycle as req): one instruction per cycle.
- Reset asserted mid-request abandons the transfer; memory must tolerate a dropped `imem_req`.
- No instruction is lost or duplicated across any stall pattern.

## Test plan
- Reset with `RESET_PC` = 0, memory acking 1 cycle after req, no stall:
  - `imem_addr` sequence 0x0, 0x4, 0x8, 0xC.
  - `pc_out` follows the same sequence, `pc_plus8` = 0x8, 0xC, 0x10 in order.
- Decode: `instr` 0xE3A01005 → `ext_imm` 00, `imm24` 0xA01005; 0xE5912004 → 10; 0xEAFFFFFE → 01, `imm24` 0xFFFFFE; 0xEF000000 → 11.
- Zero-wait memory with `stall` raised for 3 cycles while acks arrive:
  - `imem_req` drops after one skid capture.
  - After release: instructions 0x0, 0x4, 0x8, 0xC delivered in order, no gaps, no duplicates.
- Memory latency 3 cycles; `branch_taken` with target 0x100 on the cycle after req to 0x8:
  - `imem_addr` stays 0x8 until ack; data from 0x8 is never presented.
  - Next req addr is 0x100; `instr_valid` stays 0 until 0x100 returns.
- `branch_taken` (target 0x40) in the same cycle as an ack for 0x10:
  - 0x10 is dropped.
  - Next `imem_addr` is 0x40; next `pc_out` is 0x40.
- `rst_n` pulsed low mid-DISCARD:
  - All outputs immediately take their reset values.
  - Fetch restarts at `RESET_PC` two cycles after release.
